banked_regfile_v2: RTL
======================

Name: banked_regfile_v2

Overview:
Parametrised ARMv7 banked register file for the CPU datapath, successor to the three-read/one-write banked file.
- Mode-banked R8–R14 per ARM rules, with configurable data width and read-port count.
- Second write port for base-register writeback.
- Registered PC with auto-increment and a pipeline read offset for R15.
- Same-cycle write-to-read bypass.
- Registered error flags.

Parameters:
DATA_W, 32, register width in bits (≥16)
NUM_RD, 3, number of read ports (1–4)
RESET_PC, 0, PC value loaded at reset
PC_OFFSET, 8, added to PC when R15 is read through a read port
BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads

Ports:
clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous reset, active-low
M  in  5  processor mode from CPSR
R_Addr  in  4*NUM_RD  read addresses; port k in bits [4k+3:4k]
R_Data  out  DATA_W*NUM_RD  read data; port k in bits [DATA_W*(k+1)-1:DATA_W*k]
W_Addr  in  4  write port 1 address
W_Data  in  DATA_W  write port 1 data
Write_Reg  in  1  write port 1 enable
W2_Addr  in  4  write port 2 (base writeback) address
W2_Data  in  DATA_W  write port 2 data
Write_Reg2  in  1  write port 2 enable
PC_New  in  DATA_W  PC load value
Write_PC  in  1  PC load enable
PC_Inc  in  1  PC increment enable
R_Data_PC  out  DATA_W  current PC register, raw
err1  out  1  registered: illegal mode on an enabled access last cycle
err2  out  1  registered: write collision or W_Addr=15 last cycle

Behaviour:
- Legal modes:
  - usr 10000, fiq 10001, irq 10010, svc 10011
  - mon 10110, abt 10111, hyp 11010, und 11011, sys 11111
  - Any other M is illegal.
- Physical banking:
  - R0–R7 shared by all modes.
  - R8–R12: fiq bank, plus one common bank for all other modes.
  - R13: separate copies for usr/sys (shared), fiq, irq, svc, mon, abt, hyp, und.
  - R14: separate copies for usr/sys (shared), fiq, irq, svc, mon, abt, und. hyp uses the usr R14.
- Reads are combinational and mapped through current M.
  - Address 15 returns PC + PC_OFFSET (mod 2^DATA_W).
  - Illegal M: every read port returns 0.
- Writes are committed at rising clk, mapped through current M.
  - W_Addr=15 or W2_Addr=15 with enable: write ignored, err2 set next cycle. The PC is written only via Write_PC.
  - Both ports enabled with the same architectural address: port 1 wins, port 2 dropped, err2 set next cycle.
  - Illegal M with any enable (Write_Reg, Write_Reg2, Write_PC, PC_Inc): no state changes at all, err1 set next cycle.
- Bypass (BYPASS=1): a read whose mapped physical register equals a same-cycle enabled, non-dropped write target returns that write's data. Port 1 takes precedence over port 2. With BYPASS=0, the old value is returned until the edge.
- PC update:
  - Write_PC=1: PC ← PC_New. This has priority over PC_Inc.
  - Else PC_Inc=1: PC ← PC+4, wrapping at 2^DATA_W.
  - Else PC holds.
- err1 and err2 are single-cycle pulses recomputed every cycle (not sticky).
- Reset (Rst=0 at clk edge):
  - All banked and shared registers ← 0; PC ← RESET_PC; err1, err2 ← 0.
  - Reset overrides every simultaneous write, increment or load.
  - Mid-operation reset discards any in-flight write.
- After reset, outputs read as:
  - R_Data_PC = RESET_PC.
  - A read of R15 = RESET_PC + PC_OFFSET.
  - A read of any other address = 0 (given a legal M).
- Mode change takes effect on the same-cycle combinational read mapping; there is no latency.

Test Plan:
- Reset, then read:
  - Rst=0 for 2 cycles.
  - Read R0, R13 and R15 with M=usr → 0, 0, 0x00000008.
  - R_Data_PC=0; err1=err2=0.
- Banking:
  - Write R13=0xFFFF0000 in usr, then R13=0xAAAAAAAA in irq.
  - Read R13 in sys → 0xFFFF0000; in irq → 0xAAAAAAAA; in svc → 0.
  - Write R14=0x12345678 in usr; read R14 in hyp → 0x12345678.
- FIQ bank:
  - Write R8=0x11110008 in fiq.
  - Read R8 in usr → 0; in fiq → 0x11110008.
  - R7 written in fiq =0x77 reads 0x77 in und.
- Dual write and collision:
  - Same cycle: W_Addr=3/0xA5A5A5A5 and W2_Addr=4/0x5A5A5A5A → R3, R4 updated, err2=0.
  - Next cycle: both ports to R5, 0x1 vs 0x2 → R5=0x1, err2=1 for exactly one cycle.
- Bypass and illegal mode:
  - Write R2=0xDEADBEEF while R_Addr port0=2 → same-cycle R_Data port0=0xDEADBEEF.
  - M=00000 with Write_Reg=1 to R2=0x0 → R2 stays 0xDEADBEEF, err1=1 for one cycle, reads return 0.
- PC control:
  - Write_PC=1 with PC_New=0xFFFFFFFC, then PC_Inc=1 for 2 cycles → R_Data_PC 0xFFFFFFFC, 0x00000000, 0x00000004.
  - Write_PC and PC_Inc both high with PC_New=0x100 → 0x100.
  - Rst=0 during PC_Inc → RESET_PC.

Source files
------------

// File: rtl/banked_regfile_v2.sv
// ARMv7 mode-banked register file: NUM_RD combinational read ports, two write ports, registered PC and error pulses.
// Latency: reads combinational (with optional same-cycle write bypass), writes at next edge; always ready, no backpressure.
module banked_regfile_v2 #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_RD    = 3,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] PC_OFFSET = DATA_W'(8),
    parameter bit                BYPASS    = 1'b1
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic [4:0]               M,
    input  logic [4*NUM_RD-1:0]      R_Addr,
    output logic [DATA_W*NUM_RD-1:0] R_Data,
    input  logic [3:0]               W_Addr,
    input  logic [DATA_W-1:0]        W_Data,
    input  logic                     Write_Reg,
    input  logic [3:0]               W2_Addr,
    input  logic [DATA_W-1:0]        W2_Data,
    input  logic                     Write_Reg2,
    input  logic [DATA_W-1:0]        PC_New,
    input  logic                     Write_PC,
    input  logic                     PC_Inc,
    output logic [DATA_W-1:0]        R_Data_PC,
    output logic                     err1,
    output logic                     err2
);

    localparam int unsigned NUM_PHYS = 33;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_MON = 5'b10110;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_HYP = 5'b11010;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    function automatic logic mode_legal(input logic [4:0] m);
        logic ok;
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_MON,
            MODE_ABT, MODE_HYP, MODE_UND, MODE_SYS: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Physical layout: 0-7 shared, 8-12 common high regs, 13-17 fiq R8-R12,
    // 18-25 R13 copies (usr/sys, fiq, irq, svc, mon, abt, hyp, und),
    // 26-32 R14 copies (usr/sys/hyp, fiq, irq, svc, mon, abt, und).
    function automatic logic [5:0] phys_idx(input logic [3:0] a, input logic [4:0] m);
        logic [5:0] idx;
        idx = {2'b00, a};
        case (a)
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
                if (m == MODE_FIQ) begin
                    idx = {2'b00, a} + 6'd5;
                end
            end
            4'd13: begin
                case (m)
                    MODE_FIQ: idx = 6'd19;
                    MODE_IRQ: idx = 6'd20;
                    MODE_SVC: idx = 6'd21;
                    MODE_MON: idx = 6'd22;
                    MODE_ABT: idx = 6'd23;
                    MODE_HYP: idx = 6'd24;
                    MODE_UND: idx = 6'd25;
                    default:  idx = 6'd18;
                endcase
            end
            4'd14: begin
                case (m)
                    MODE_FIQ: idx = 6'd27;
                    MODE_IRQ: idx = 6'd28;
                    MODE_SVC: idx = 6'd29;
                    MODE_MON: idx = 6'd30;
                    MODE_ABT: idx = 6'd31;
                    MODE_UND: idx = 6'd32;
                    default:  idx = 6'd26;
                endcase
            end
            default: idx = {2'b00, a};
        endcase
        return idx;
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_PHYS];
    logic [DATA_W-1:0] regs_d [NUM_PHYS];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic              err1_q;
    logic              err1_d;
    logic              err2_q;
    logic              err2_d;

    logic              mode_ok;
    logic              any_en;
    logic              w1_to_pc;
    logic              w2_to_pc;
    logic              addr_clash;
    logic              w1_eff;
    logic              w2_eff;
    logic [5:0]        w1_idx;
    logic [5:0]        w2_idx;

    logic [3:0]        rd_addr;
    logic [5:0]        rd_idx;
    logic [DATA_W-1:0] rd_val;

    always_comb begin
        mode_ok    = mode_legal(M);
        any_en     = Write_Reg | Write_Reg2 | Write_PC | PC_Inc;
        w1_to_pc   = Write_Reg  && (W_Addr  == 4'hF);
        w2_to_pc   = Write_Reg2 && (W2_Addr == 4'hF);
        addr_clash = Write_Reg && Write_Reg2 && (W_Addr == W2_Addr);
        // An illegal mode freezes all state, so both write ports are gated by mode_ok.
        w1_eff     = mode_ok && Write_Reg  && !w1_to_pc;
        w2_eff     = mode_ok && Write_Reg2 && !w2_to_pc && !addr_clash;
        w1_idx     = phys_idx(W_Addr,  M);
        w2_idx     = phys_idx(W2_Addr, M);
        err1_d     = !mode_ok && any_en;
        err2_d     = w1_to_pc || w2_to_pc || addr_clash;
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_PHYS); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (w2_eff) begin
            regs_d[w2_idx] = W2_Data;
        end
        if (w1_eff) begin
            regs_d[w1_idx] = W_Data;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (mode_ok) begin
            if (Write_PC) begin
                pc_d = PC_New;
            end else if (PC_Inc) begin
                pc_d = pc_q + DATA_W'(4);
            end
        end
    end

    always_comb begin
        R_Data  = '0;
        rd_addr = '0;
        rd_idx  = '0;
        rd_val  = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            rd_addr = R_Addr[4*k +: 4];
            rd_idx  = phys_idx(rd_addr, M);
            if (!mode_ok) begin
                rd_val = '0;
            end else if (rd_addr == 4'hF) begin
                rd_val = pc_q + PC_OFFSET;
            end else if (BYPASS && w1_eff && (rd_idx == w1_idx)) begin
                rd_val = W_Data;
            end else if (BYPASS && w2_eff && (rd_idx == w2_idx)) begin
                rd_val = W2_Data;
            end else begin
                rd_val = regs_q[rd_idx];
            end
            R_Data[DATA_W*k +: DATA_W] = rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            for (int i = 0; i < int'(NUM_PHYS); i++) begin
                regs_q[i] <= '0;
            end
            pc_q   <= RESET_PC;
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
            err1_q <= err1_d;
            err2_q <= err2_d;
        end
    end

    assign R_Data_PC = pc_q;
    assign err1      = err1_q;
    assign err2      = err2_q;

endmodule
